// File: rtl/dcache_ctrl.sv
// dcache_ctrl - miss/write sequencer for an 8-set direct-mapped, write-through,
// no-write-allocate data cache. Owns the valid/tag store, stalls the CPU,
// refills on load miss and forwards every store to main memory.
// Optional feature: define DCACHE_PERF_CNT_EN to add hit/miss/write counters.

`ifndef DATA_ADDR_MODE_B
`define DATA_ADDR_MODE_B  3'b000
`endif
`ifndef DATA_ADDR_MODE_W
`define DATA_ADDR_MODE_W  3'b010
`endif
`ifndef DATA_ADDR_MODE_BU
`define DATA_ADDR_MODE_BU 3'b100
`endif

module dcache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [2:0]            i_cpu_addr_mode,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic                  o_cpu_stall,
  output logic [2:0]            o_arr_set,
  output logic                  o_arr_we,
  output logic [3:0]            o_arr_byte_en,
  output logic [DATA_WIDTH-1:0] o_arr_wdata,
  input  logic [DATA_WIDTH-1:0] i_arr_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [3:0]            o_mem_byte_en,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]           o_hit_cnt,
  output logic [31:0]           o_miss_cnt,
  output logic [31:0]           o_wr_cnt
`endif
);

  localparam int TAG_W = ADDR_WIDTH - 5;
  localparam int WA_W  = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;

  state_t                r_state;
  logic [NUM_SETS-1:0]   r_valid;
  logic [TAG_W-1:0]      r_tag [NUM_SETS];
  logic [WA_W-1:0]       r_waddr;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_hit;
  logic                  r_mem_req;
  logic                  r_mem_we;

  logic [2:0]            w_set;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic                  w_is_byte;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_lanes;
  logic [7:0]            w_sel_byte;
  logic [DATA_WIDTH-1:0] w_load_fmt;
  logic                  w_ack;
  logic [2:0]            w_lat_set;

  assign w_set      = i_cpu_addr[4:2];
  assign w_tag      = i_cpu_addr[ADDR_WIDTH-1:5];
  assign w_hit      = i_cpu_req & r_valid[w_set] & (r_tag[w_set] == w_tag);
  assign w_is_byte  = (i_cpu_addr_mode == `DATA_ADDR_MODE_B) ||
                      (i_cpu_addr_mode == `DATA_ADDR_MODE_BU);
  assign w_be       = w_is_byte ? (4'b0001 << i_cpu_addr[1:0]) : 4'b1111;
  assign w_lanes    = w_is_byte ? {4{i_cpu_wdata[7:0]}} : i_cpu_wdata;
  assign w_ack      = i_mem_ack & r_mem_req;
  assign w_lat_set  = r_waddr[2:0];

  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = {r_waddr, 2'b00};
  assign o_mem_byte_en = r_be;
  assign o_mem_wdata   = r_wdata;
  assign o_arr_set     = (r_state == S_IDLE) ? w_set : w_lat_set;

  // Select the addressed byte lane of the array word and shape the load result
  always_comb begin
    w_sel_byte = i_arr_rdata[7:0];
    case (i_cpu_addr[1:0])
      2'd1:    w_sel_byte = i_arr_rdata[15:8];
      2'd2:    w_sel_byte = i_arr_rdata[23:16];
      2'd3:    w_sel_byte = i_arr_rdata[31:24];
      default: w_sel_byte = i_arr_rdata[7:0];
    endcase
    if (i_cpu_addr_mode == `DATA_ADDR_MODE_B)
      w_load_fmt = {{24{w_sel_byte[7]}}, w_sel_byte};
    else if (i_cpu_addr_mode == `DATA_ADDR_MODE_BU)
      w_load_fmt = {24'h0, w_sel_byte};
    else
      w_load_fmt = i_arr_rdata;
  end

  // Stall, load data and array write strobes must react in the same cycle, so they are combinational
  always_comb begin
    o_cpu_stall   = 1'b0;
    o_cpu_rdata   = '0;
    o_arr_we      = 1'b0;
    o_arr_byte_en = r_be;
    o_arr_wdata   = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (i_cpu_req) begin
          if (i_cpu_we)   o_cpu_stall = 1'b1;
          else if (w_hit) o_cpu_rdata = w_load_fmt;
          else            o_cpu_stall = 1'b1;
        end
      end
      S_REFILL: begin
        o_cpu_stall   = 1'b1;
        o_arr_we      = w_ack;
        o_arr_byte_en = 4'b1111;
        o_arr_wdata   = i_mem_rdata;
      end
      S_WRITE: begin
        o_cpu_stall = ~w_ack;
        o_arr_we    = w_ack & r_hit;
      end
      default: ;
    endcase
    // Keep the CPU and array quiet for the whole time reset is held, even with a request pending
    if (!i_rst_n) begin
      o_cpu_stall = 1'b0;
      o_arr_we    = 1'b0;
    end
  end

  // Sequencer: accept one request in IDLE, then run a refill or a write-through to completion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_valid   <= '0;
      for (int i = 0; i < NUM_SETS; i++) r_tag[i] <= '0;
      r_waddr   <= '0;
      r_be      <= 4'b1111;
      r_wdata   <= '0;
      r_hit     <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cpu_req && i_cpu_we) begin
            r_waddr   <= i_cpu_addr[ADDR_WIDTH-1:2];
            r_be      <= w_be;
            r_wdata   <= w_lanes;
            r_hit     <= w_hit;
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b1;
            r_state   <= S_WRITE;
          end else if (i_cpu_req && !w_hit) begin
            r_waddr   <= i_cpu_addr[ADDR_WIDTH-1:2];
            r_be      <= 4'b1111;
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b0;
            r_state   <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (w_ack) begin
            r_valid[w_lat_set] <= 1'b1;
            r_tag[w_lat_set]   <= r_waddr[WA_W-1:3];
            r_mem_req          <= 1'b0;
            r_state            <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // Event counters: IDLE load hits, IDLE-to-REFILL misses and completed writes; all wrap naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
      o_wr_cnt   <= '0;
    end else begin
      if (r_state == S_IDLE && i_cpu_req && !i_cpu_we && w_hit)  o_hit_cnt  <= o_hit_cnt + 32'd1;
      if (r_state == S_IDLE && i_cpu_req && !i_cpu_we && !w_hit) o_miss_cnt <= o_miss_cnt + 32'd1;
      if (r_state == S_WRITE && w_ack)                           o_wr_cnt   <= o_wr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl - scoreboard bench for dcache_ctrl. The reference model is a
// flat main-memory image plus a valid/tag table: with a write-through cache
// every load must return the current memory word, and hit/miss follows from
// the tag table alone.

`timescale 1ns/1ps

`ifndef DATA_ADDR_MODE_B
`define DATA_ADDR_MODE_B  3'b000
`endif
`ifndef DATA_ADDR_MODE_W
`define DATA_ADDR_MODE_W  3'b010
`endif
`ifndef DATA_ADDR_MODE_BU
`define DATA_ADDR_MODE_BU 3'b100
`endif

module tb_dcache_ctrl;

  typedef struct {
    bit          isLoad;
    logic [31:0] data;
    int          stalls;
  } expRsp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          arrWe;
    logic [2:0]  set;
  } expMem_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        cpuReq = 1'b0;
  logic        cpuWe = 1'b0;
  logic [2:0]  cpuMode = `DATA_ADDR_MODE_W;
  logic [31:0] cpuAddr = '0;
  logic [31:0] cpuWdata = '0;
  logic [31:0] cpuRdata;
  logic        cpuStall;
  logic [2:0]  arrSet;
  logic        arrWe;
  logic [3:0]  arrByteEn;
  logic [31:0] arrWdata;
  logic [31:0] arrRdata;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memByteEn;
  logic [31:0] memWdata;
  logic        memAck = 1'b0;
  logic [31:0] memRdata = '0;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hitCnt, missCnt, wrCnt;
`endif

  logic [31:0] arrMem  [8];
  logic [31:0] physMem [64];
  logic [31:0] refMem  [64];
  bit          refValid [8];
  logic [2:0]  refTag   [8];
  bit          memReady = 1'b0;
  int          memLat = 1;

  expRsp_t     expQ [$];
  expMem_t     memQ [$];
  int          passCnt = 0;
  int          totalCnt = 0;
  int          stallCnt = 0;
  expRsp_t     monE;
  expMem_t     monM;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .i_cpu_req       (cpuReq),
    .i_cpu_we        (cpuWe),
    .i_cpu_addr_mode (cpuMode),
    .i_cpu_addr      (cpuAddr),
    .i_cpu_wdata     (cpuWdata),
    .o_cpu_rdata     (cpuRdata),
    .o_cpu_stall     (cpuStall),
    .o_arr_set       (arrSet),
    .o_arr_we        (arrWe),
    .o_arr_byte_en   (arrByteEn),
    .o_arr_wdata     (arrWdata),
    .i_arr_rdata     (arrRdata),
    .o_mem_req       (memReq),
    .o_mem_we        (memWe),
    .o_mem_addr      (memAddr),
    .o_mem_byte_en   (memByteEn),
    .o_mem_wdata     (memWdata),
    .i_mem_ack       (memAck),
    .i_mem_rdata     (memRdata)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .o_hit_cnt       (hitCnt),
    .o_miss_cnt      (missCnt),
    .o_wr_cnt        (wrCnt)
`endif
  );

  // The cache data array the controller drives: byte-lane writable, combinational read
  assign arrRdata = arrMem[arrSet];
  always @(posedge clk) begin
    if (arrWe)
      for (int l = 0; l < 4; l++)
        if (arrByteEn[l]) arrMem[arrSet][8*l +: 8] <= arrWdata[8*l +: 8];
  end

  // Main memory: acknowledges on the memLat-th cycle of mem_req, abandons on reset
  initial begin
    int reqCnt;
    int widx;
    reqCnt = 0;
    wait (memReady);
    for (int i = 0; i < 64; i++) physMem[i] = refMem[i];
    forever begin
      @(posedge clk);
      #1;
      if (memAck) begin
        memAck = 1'b0;
      end else if (memReq) begin
        reqCnt++;
        if (reqCnt >= memLat) begin
          reqCnt = 0;
          memAck = 1'b1;
          widx = int'(memAddr[7:2]);
          if (memWe) begin
            for (int l = 0; l < 4; l++)
              if (memByteEn[l]) physMem[widx][8*l +: 8] = memWdata[8*l +: 8];
          end else begin
            memRdata = physMem[widx];
          end
        end
      end else begin
        reqCnt = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic finishRun();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  endtask

  function automatic logic [31:0] fmtLoad(input logic [2:0] mode, input logic [1:0] off, input logic [31:0] w);
    logic [7:0] b;
    b = w[8*off +: 8];
    if (mode == `DATA_ADDR_MODE_B)  return {{24{b[7]}}, b};
    if (mode == `DATA_ADDR_MODE_BU) return {24'h0, b};
    return w;
  endfunction

  // Predict the response and memory traffic of one request, then present it until the CPU is released
  task automatic applyStimulus(input bit we, input logic [2:0] mode, input logic [31:0] addr,
                               input logic [31:0] wdata, input int lat);
    expRsp_t e;
    expMem_t m;
    int      widx;
    int      cycles;
    bit      hit;
    bit      isByte;
    logic [2:0] set;
    logic [2:0] tag;
    widx   = int'(addr[7:2]);
    set    = addr[4:2];
    tag    = addr[7:5];
    hit    = refValid[set] && (refTag[set] == tag);
    isByte = (mode == `DATA_ADDR_MODE_B) || (mode == `DATA_ADDR_MODE_BU);
    m.addr = {addr[31:2], 2'b00};
    m.set  = set;
    if (!we) begin
      e.isLoad = 1'b1;
      e.data   = fmtLoad(mode, addr[1:0], refMem[widx]);
      e.stalls = hit ? 0 : lat + 1;
      if (!hit) begin
        m.we = 1'b0; m.be = 4'hF; m.wdata = refMem[widx]; m.arrWe = 1'b1;
        memQ.push_back(m);
        refValid[set] = 1'b1;
        refTag[set]   = tag;
      end
    end else begin
      m.we    = 1'b1;
      m.be    = isByte ? 4'(1 << addr[1:0]) : 4'hF;
      m.wdata = isByte ? {4{wdata[7:0]}} : wdata;
      m.arrWe = hit;
      memQ.push_back(m);
      for (int l = 0; l < 4; l++)
        if (m.be[l]) refMem[widx][8*l +: 8] = m.wdata[8*l +: 8];
      e.isLoad = 1'b0;
      e.data   = '0;
      e.stalls = lat;
    end
    expQ.push_back(e);
    memLat   = lat;
    cpuReq   = 1'b1;
    cpuWe    = we;
    cpuMode  = mode;
    cpuAddr  = addr;
    cpuWdata = wdata;
    cycles   = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (cpuStall && cycles < 100);
    if (cpuStall) begin
      totalCnt++;
      $display("[TB] FAIL reqTimeout: stall still 1 after %0d cycles, expected 0", cycles);
      finishRun();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a CPU request or a memory transaction
  always @(negedge clk) begin
    if (!rstN) begin
      stallCnt = 0;
      expQ.delete();
      memQ.delete();
    end else begin
      if (memReq && memAck) begin
        if (memQ.size() == 0) begin
          totalCnt++;
          $display("[TB] FAIL unexpectedMemAck: got transaction at 0x%08h, expected none", memAddr);
        end else begin
          monM = memQ.pop_front();
          checkOutput("memWe", 32'(memWe), 32'(monM.we));
          checkOutput("memAddr", memAddr, monM.addr);
          checkOutput("memByteEn", 32'(memByteEn), 32'(monM.be));
          if (monM.we) checkOutput("memWdata", memWdata, monM.wdata);
          checkOutput("arrWeAtAck", 32'(arrWe), 32'(monM.arrWe));
          if (monM.arrWe) begin
            checkOutput("arrSet", 32'(arrSet), 32'(monM.set));
            checkOutput("arrByteEn", 32'(arrByteEn), 32'(monM.be));
            checkOutput("arrWdata", arrWdata, monM.wdata);
          end
        end
      end
      if (cpuReq) begin
        if (cpuStall) begin
          stallCnt++;
        end else begin
          if (expQ.size() == 0) begin
            totalCnt++;
            $display("[TB] FAIL unexpectedDone: got completion at 0x%08h, expected none", cpuAddr);
          end else begin
            monE = expQ.pop_front();
            checkOutput("stallCycles", 32'(stallCnt), 32'(monE.stalls));
            if (monE.isLoad) checkOutput("loadData", cpuRdata, monE.data);
          end
          stallCnt = 0;
        end
      end
    end
  end

  // Watchdog so a wedged handshake still reaches the summary line
  initial begin
    #2000000;
    totalCnt++;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    finishRun();
  end

  // Directed walk through the cache scenarios, an asynchronous reset mid-refill, then random traffic
  initial begin
    logic [2:0] modes [6];
    modes[0] = `DATA_ADDR_MODE_W;  modes[1] = `DATA_ADDR_MODE_W;
    modes[2] = `DATA_ADDR_MODE_B;  modes[3] = `DATA_ADDR_MODE_BU;
    modes[4] = 3'b111;             modes[5] = 3'b001;
    for (int i = 0; i < 64; i++) refMem[i] = $urandom;
    refMem[16] = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) begin refValid[i] = 1'b0; refTag[i] = '0; end
    memReady = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rstMemReq", 32'(memReq), 32'd0);
    checkOutput("rstStall", 32'(cpuStall), 32'd0);
    checkOutput("rstRdata", cpuRdata, 32'd0);
    checkOutput("rstArrWe", 32'(arrWe), 32'd0);
    #2 rstN = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1'b0, `DATA_ADDR_MODE_W,  32'h40, 32'h0, 3);
    applyStimulus(1'b0, `DATA_ADDR_MODE_W,  32'h40, 32'h0, 3);
    applyStimulus(1'b0, `DATA_ADDR_MODE_B,  32'h43, 32'h0, 3);
    applyStimulus(1'b0, `DATA_ADDR_MODE_BU, 32'h43, 32'h0, 3);
    applyStimulus(1'b1, `DATA_ADDR_MODE_B,  32'h41, 32'h55, 2);
    applyStimulus(1'b0, `DATA_ADDR_MODE_W,  32'h40, 32'h0, 2);
    applyStimulus(1'b1, `DATA_ADDR_MODE_W,  32'h60, 32'h12345678, 2);
    applyStimulus(1'b0, `DATA_ADDR_MODE_W,  32'h40, 32'h0, 2);
    applyStimulus(1'b0, `DATA_ADDR_MODE_W,  32'h60, 32'h0, 1);
    applyStimulus(1'b0, `DATA_ADDR_MODE_W,  32'h40, 32'h0, 4);
    cpuReq = 1'b0;
    @(posedge clk); #1;

    memLat  = 6;
    cpuReq  = 1'b1;
    cpuWe   = 1'b0;
    cpuMode = `DATA_ADDR_MODE_W;
    cpuAddr = 32'h80;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("midRefillMemReq", 32'(memReq), 32'd1);
    checkOutput("midRefillStall", 32'(cpuStall), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("asyncRstMemReq", 32'(memReq), 32'd0);
    checkOutput("asyncRstStall", 32'(cpuStall), 32'd0);
    cpuReq = 1'b0;
    for (int i = 0; i < 8; i++) refValid[i] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rstN = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, `DATA_ADDR_MODE_W, 32'h40, 32'h0, 2);

    for (int n = 0; n < 200; n++) begin
      applyStimulus($urandom_range(0, 2) == 0, modes[$urandom_range(0, 5)],
                    32'($urandom_range(0, 127)), $urandom, $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) begin
        cpuReq = 1'b0;
        @(posedge clk); #1;
      end
    end
    cpuReq = 1'b0;
    repeat (3) @(posedge clk);
    checkOutput("expQDrained", 32'(expQ.size()), 32'd0);
    checkOutput("memQDrained", 32'(memQ.size()), 32'd0);
    finishRun();
  end

endmodule
